// File: rtl/flopr_pipe_if.sv
// Handshake bus for flopr_pipe: upstream valid/ready/data, downstream valid/ready/data,
// plus flush and occupancy.
interface flopr_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/flopr_pipe.sv
// Two-entry skid-buffered pipeline register with fully registered valid/ready,
// synchronous flush and asynchronous active-low reset.
module flopr_pipe #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h0000_0000)
) (
  input logic         clk,
  input logic         rst,
  flopr_pipe_if.slave bus
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_nx;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept_c;
  logic             drain_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign drain_c  = out_valid_q & bus.out_ready;

  // Next-state and datapath selection; flush overrides everything.
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (bus.flush) begin
      state_nx = EMPTY;
      main_nx  = RESET_VAL;
      skid_nx  = RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            state_nx = BUSY;
            main_nx  = bus.in_data;
          end
        end
        BUSY: begin
          if (accept_c && drain_c) begin
            main_nx = bus.in_data;
          end else if (accept_c) begin
            state_nx = FULL;
            skid_nx  = bus.in_data;
          end else if (drain_c) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (drain_c) begin
            state_nx = BUSY;
            main_nx  = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // in_ready is kept separately so it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      main_q      <= main_nx;
      skid_q      <= skid_nx;
      in_ready_q  <= (state_nx != FULL);
      out_valid_q <= (state_nx != EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.count     = state;

endmodule

// File: tb/tb_flopr_pipe.sv
// Bench for flopr_pipe: a 32-bit and an 8-bit instance share stimulus and are both
// checked every cycle against a 2-deep queue model, plus directed literal checks.
module tb_flopr_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fl  = 1'b0;
  logic        iv  = 1'b0;
  logic [31:0] id  = '0;
  logic        ordy = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  bit          m_rdy = 1'b0;

  flopr_pipe_if #(.WIDTH(32)) b32 ();
  flopr_pipe_if #(.WIDTH(8))  b8  ();

  assign b32.flush     = fl;
  assign b32.in_valid  = iv;
  assign b32.in_data   = id;
  assign b32.out_ready = ordy;
  assign b8.flush      = fl;
  assign b8.in_valid   = iv;
  assign b8.in_data    = id[7:0];
  assign b8.out_ready  = ordy;

  flopr_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  flopr_pipe #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    iv = v; id = d; ordy = r; fl = f;
  endtask

  // Reference: an ordered queue of at most two items; ready reflects room after the last edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_rdy = 1'b0;
    end else begin
      bit acc, dr;
      acc = iv && m_rdy;
      dr  = (mq.size() > 0) && ordy;
      if (fl) begin
        mq.delete();
      end else begin
        if (dr)  void'(mq.pop_front());
        if (acc) mq.push_back(id);
      end
      m_rdy = (mq.size() < 2);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [31:0] head;
    chk("count32", 32'(b32.count), 32'(mq.size()));
    chk("valid32", 32'(b32.out_valid), 32'(mq.size() != 0));
    chk("ready32", 32'(b32.in_ready), 32'(m_rdy));
    chk("count8",  32'(b8.count), 32'(mq.size()));
    chk("valid8",  32'(b8.out_valid), 32'(mq.size() != 0));
    chk("ready8",  32'(b8.in_ready), 32'(m_rdy));
    if (mq.size() > 0) begin
      head = mq[0];
      chk("data32", b32.out_data, head);
      chk("data8", 32'(b8.out_data), 32'(head[7:0]));
    end
  end

  initial begin
    // Reset state before any edge
    #2;
    chk("rst_valid", 32'(b32.out_valid), 32'd0);
    chk("rst_ready", 32'(b32.in_ready), 32'd0);
    chk("rst_count", 32'(b32.count), 32'd0);
    chk("rst_data",  b32.out_data, 32'h0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    drive(1'b1, 32'h12345678, 1'b1, 1'b0);

    // First edge after release only raises in_ready
    @(negedge clk);
    chk("rel_ready", 32'(b32.in_ready), 32'd1);
    chk("rel_valid", 32'(b32.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(b32.out_valid), 32'd1);
    chk("lat_data",  b32.out_data, 32'h12345678);
    chk("lat_count", 32'(b32.count), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_drain", 32'(b32.count), 32'd0);

    // Back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      @(negedge clk);
      chk("stream_data",  b32.out_data, 32'(i));
      chk("stream_count", 32'(b32.count), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_end", 32'(b32.count), 32'd0);

    // Backpressure fill, ignored offer while full, then drain A then B
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(b32.count), 32'd2);
    chk("full_ready", 32'(b32.in_ready), 32'd0);
    chk("full_data",  b32.out_data, 32'hAAAA_0001);
    drive(1'b1, 32'hDDDD_0004, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_data",  b32.out_data, 32'hAAAA_0001);
    chk("hold_count", 32'(b32.count), 32'd2);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_b",     b32.out_data, 32'hBBBB_0002);
    chk("drain_count", 32'(b32.count), 32'd1);
    @(negedge clk);
    chk("drain_empty", 32'(b32.count), 32'd0);

    // Flush while full with C offered
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_count", 32'(b32.count), 32'd0);
    chk("flush_valid", 32'(b32.out_valid), 32'd0);
    chk("flush_data",  b32.out_data, 32'h0);
    chk("flush_ready", 32'(b32.in_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_c", 32'(b32.out_valid), 32'd0);
    end

    // Asynchronous reset while full
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(b32.out_valid), 32'd0);
    chk("arst_ready", 32'(b32.in_ready), 32'd0);
    chk("arst_count", 32'(b32.count), 32'd0);
    chk("arst_data",  b32.out_data, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_stale", 32'(b32.out_valid), 32'd0);
    end

    // Random traffic, checked by the per-cycle compare
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flopr_pipe.md
FLOPR_PIPE -- requirements
Module: flopr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data path width in bits.
REQ-002 SHALL have parameter RESET_VAL, default 32'h00000000 truncated to WIDTH, value loaded into data registers on reset/flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held data.
REQ-006 SHALL have port in_valid  input  1  upstream data present.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream data.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid item.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  head item, driven directly from the main register.
REQ-012 SHALL have port count  output  2  occupancy: 0, 1 or 2.

Function
REQ-013 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready, both evaluated on the same edge.
REQ-014 SHALL hold a main register and a skid register, each WIDTH bits, in a 3-state FSM: EMPTY (count 0), BUSY (count 1), FULL (count 2).
REQ-015 SHALL drive out_valid=1 in BUSY and FULL only; in_ready=1 in EMPTY and BUSY only, and both are registered (no combinational path from out_ready to in_ready).
REQ-016 EMPTY: accept -> BUSY, main<=in_data; otherwise hold.
REQ-017 BUSY: accept & drain -> BUSY, main<=in_data; accept & !drain -> FULL, skid<=in_data; !accept & drain -> EMPTY; neither -> hold.
REQ-018 FULL: drain -> BUSY, main<=skid; otherwise hold; in_valid is ignored.
REQ-019 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL give latency of exactly one cycle from accept into EMPTY to out_valid=1.
REQ-021 SHALL sustain one transfer per cycle with in_valid and out_ready held high continuously.
REQ-022 flush=1 SHALL take priority over all other inputs: next state EMPTY, main and skid <= RESET_VAL, and any item offered in that cycle is discarded and counts as not accepted.
REQ-023 SHALL never overwrite the skid register while in FULL, and never lose or duplicate an item outside flush/reset.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for clk, force EMPTY, main=skid=RESET_VAL, out_valid=0, in_ready=0 and count=0.
REQ-025 in_ready SHALL rise to 1 on the first rising clk edge after rst returns to 1; no item is accepted before that edge.
REQ-026 rst asserted mid-transfer SHALL drop all held items; no partial state survives.

Verification
REQ-027 Reset release, in_valid=1, in_data=32'h12345678, out_ready=1 -> in_ready=1 after first edge; out_valid=1 and out_data=32'h12345678 one cycle after accept; count=1.
REQ-028 Stream of 8 words 1..8 with out_ready=1 throughout -> outputs 1..8 in order on consecutive cycles, count stays 1.
REQ-029 Send A,B with out_ready=0 -> count=2, in_ready=0, out_data=A held; raise out_ready -> A then B emitted, count returns to 0 via 1.
REQ-030 FULL with A,B, assert flush for one cycle while in_valid=1, in_data=C -> count=0, out_valid=0, out_data=RESET_VAL, C never appears at out_data.
REQ-031 Assert rst=0 between clock edges while FULL -> out_valid=0, in_ready=0, count=0 before next edge; after release, no stale A/B emitted.
REQ-032 Random in_valid/out_ready with WIDTH=8 versus a 2-deep reference queue -> identical output sequence, no loss or duplication over 10000 cycles.
